// File: rtl/color_ram_pkg.sv
// Shared types and helpers for the dual-port colour RAM.
package color_ram_pkg;

    typedef logic [0:0] clr_state_t;

    localparam clr_state_t ST_IDLE  = 1'b0;
    localparam clr_state_t ST_CLEAR = 1'b1;

    function automatic int unsigned read_latency(input int unsigned out_reg);
        return (out_reg != 0) ? 2 : 1;
    endfunction

endpackage

// File: rtl/color_ram_clear_seq.sv
// Clear sequencer: walks every address once, owning the write port while busy.
module color_ram_clear_seq #(
    parameter int unsigned ADDR_W         = 10,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear_req,
    output logic              busy,
    output logic [ADDR_W-1:0] clr_addr
);
    import color_ram_pkg::*;

    localparam logic [ADDR_W-1:0] LAST = '1;

    clr_state_t        state;
    logic [ADDR_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clear_req) begin
                        state <= ST_CLEAR;
                        cnt   <= '0;
                    end
                end
                ST_CLEAR: begin
                    // A restart request wins over finishing the final address.
                    if (clear_req) begin
                        cnt <= '0;
                    end else if (cnt == LAST) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy     = (state == ST_CLEAR);
    assign clr_addr = cnt;

endmodule

// File: rtl/color_ram_dp.sv
// Dual-port colour RAM: CPU read/write port, read-only video port, built-in clear.
module color_ram_dp #(
    parameter int unsigned          DATA_W         = 4,
    parameter int unsigned          ADDR_W         = 10,
    parameter int unsigned          OUT_REG        = 0,
    parameter logic [DATA_W-1:0]    FILL           = '0,
    parameter int unsigned          CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear_req,
    output logic              busy,
    input  logic              cpu_ce,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_din,
    output logic [DATA_W-1:0] cpu_dout,
    output logic              cpu_rvalid,
    input  logic              vid_ce,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_dout,
    output logic              vid_rvalid
);
    import color_ram_pkg::*;

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned LAT   = read_latency(OUT_REG);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] clr_addr;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              cpu_rd;

    logic [DATA_W-1:0] cpu_q;
    logic              cpu_q_v;
    logic [DATA_W-1:0] vid_q;
    logic              vid_q_v;

    color_ram_clear_seq #(
        .ADDR_W         (ADDR_W),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear_seq (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear_req (clear_req),
        .busy      (busy),
        .clr_addr  (clr_addr)
    );

    always_comb begin
        wr_en   = cpu_ce & cpu_we;
        wr_addr = cpu_addr;
        wr_data = cpu_din;
        if (busy) begin
            wr_en   = 1'b1;
            wr_addr = clr_addr;
            wr_data = FILL;
        end
    end

    assign cpu_rd = cpu_ce & ~cpu_we & ~busy;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Non-blocking array reads give read-first behaviour on same-address collisions.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cpu_q   <= '0;
            cpu_q_v <= 1'b0;
            vid_q   <= '0;
            vid_q_v <= 1'b0;
        end else begin
            cpu_q_v <= cpu_rd;
            vid_q_v <= vid_ce;
            if (cpu_rd) cpu_q <= mem[cpu_addr];
            if (vid_ce) vid_q <= mem[vid_addr];
        end
    end

    generate
        if (LAT == 2) begin : g_out_reg
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cpu_dout   <= '0;
                    cpu_rvalid <= 1'b0;
                    vid_dout   <= '0;
                    vid_rvalid <= 1'b0;
                end else begin
                    cpu_rvalid <= cpu_q_v;
                    vid_rvalid <= vid_q_v;
                    if (cpu_q_v) cpu_dout <= cpu_q;
                    if (vid_q_v) vid_dout <= vid_q;
                end
            end
        end else begin : g_no_out_reg
            assign cpu_dout   = cpu_q;
            assign cpu_rvalid = cpu_q_v;
            assign vid_dout   = vid_q;
            assign vid_rvalid = vid_q_v;
        end
    endgenerate

endmodule

// File: tb/tb_color_ram_dp.sv
// Self-checking bench: both latency variants driven in parallel against a memory model.
module tb_color_ram_dp;

    localparam int DEPTH = 1024;
    localparam logic [3:0] FILLV = 4'hE;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       clear_req = 1'b0;
    logic       cpu_ce = 1'b0, cpu_we = 1'b0;
    logic [9:0] cpu_addr = '0;
    logic [3:0] cpu_din = '0;
    logic       vid_ce = 1'b0;
    logic [9:0] vid_addr = '0;

    logic       busy0, busy1, cpu_rvalid0, cpu_rvalid1, vid_rvalid0, vid_rvalid1;
    logic [3:0] cpu_dout0, cpu_dout1, vid_dout0, vid_dout1;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [3:0] mm [DEPTH];
    int         clr_left, clr_ptr;
    logic       e_busy;
    logic [3:0] e_cd0, e_vd0, e_cd1, e_vd1, p_cd, p_vd;
    logic       e_cv0, e_vv0, e_cv1, e_vv1, p_cv, p_vv;

    always #5 clk = ~clk;

    color_ram_dp #(.DATA_W(4), .ADDR_W(10), .OUT_REG(0), .FILL(FILLV), .CLEAR_ON_RESET(1)) dut0 (
        .clk(clk), .reset_n(reset_n), .clear_req(clear_req), .busy(busy0),
        .cpu_ce(cpu_ce), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout0), .cpu_rvalid(cpu_rvalid0),
        .vid_ce(vid_ce), .vid_addr(vid_addr), .vid_dout(vid_dout0), .vid_rvalid(vid_rvalid0)
    );

    color_ram_dp #(.DATA_W(4), .ADDR_W(10), .OUT_REG(1), .FILL(FILLV), .CLEAR_ON_RESET(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .clear_req(clear_req), .busy(busy1),
        .cpu_ce(cpu_ce), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout1), .cpu_rvalid(cpu_rvalid1),
        .vid_ce(vid_ce), .vid_addr(vid_addr), .vid_dout(vid_dout1), .vid_rvalid(vid_rvalid1)
    );

    task automatic model_reset();
        clr_left = DEPTH; clr_ptr = 0; e_busy = 1'b1;
        e_cd0 = '0; e_vd0 = '0; e_cd1 = '0; e_vd1 = '0;
        e_cv0 = 1'b0; e_vv0 = 1'b0; e_cv1 = 1'b0; e_vv1 = 1'b0;
        p_cv = 1'b0; p_vv = 1'b0;
    endtask

    task automatic idle_inputs();
        clear_req = 1'b0; cpu_ce = 1'b0; cpu_we = 1'b0; vid_ce = 1'b0;
    endtask

    // One clock: model evaluates the current inputs, then the edge, then #1.
    task automatic tick();
        logic       busy_now, crd, vrd;
        logic [3:0] cdat, vdat;
        busy_now = (clr_left > 0);
        crd  = cpu_ce && !cpu_we && !busy_now;
        vrd  = vid_ce;
        cdat = mm[cpu_addr];
        vdat = mm[vid_addr];
        e_cv1 = p_cv; if (p_cv) e_cd1 = p_cd;
        e_vv1 = p_vv; if (p_vv) e_vd1 = p_vd;
        p_cv = crd; if (crd) p_cd = cdat;
        p_vv = vrd; if (vrd) p_vd = vdat;
        e_cv0 = crd; if (crd) e_cd0 = cdat;
        e_vv0 = vrd; if (vrd) e_vd0 = vdat;
        if (busy_now) begin
            mm[clr_ptr] = FILLV; clr_ptr++; clr_left--;
        end else if (cpu_ce && cpu_we) begin
            mm[cpu_addr] = cpu_din;
        end
        if (clear_req) begin clr_ptr = 0; clr_left = DEPTH; end
        e_busy = (clr_left > 0);
        @(posedge clk); #1;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy0 === 1'b1 && n < 3000) begin tick(); n++; end
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0; #1;
        model_reset();
        checks++;
        if ({busy0, cpu_rvalid0, vid_rvalid0, cpu_dout0, vid_dout0} !== {1'b1, 10'b0}) begin
            errors++; $display("FAIL reset_dut0 got=%b exp=%b", {busy0, cpu_rvalid0, vid_rvalid0, cpu_dout0, vid_dout0}, {1'b1, 10'b0});
        end
        checks++;
        if ({busy1, cpu_rvalid1, vid_rvalid1, cpu_dout1, vid_dout1} !== {1'b1, 10'b0}) begin
            errors++; $display("FAIL reset_dut1 got=%b exp=%b", {busy1, cpu_rvalid1, vid_rvalid1, cpu_dout1, vid_dout1}, {1'b1, 10'b0});
        end
        @(posedge clk); @(posedge clk); #1 reset_n = 1'b1;
    endtask

    task automatic test_clear_after_reset();
        int n;
        count_busy(n);
        checks++;
        if (n != DEPTH) begin errors++; $display("FAIL reset_clear_len got=%0d exp=%0d", n, DEPTH); end
        checks++;
        if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_clear_busy1 got=%b exp=0", busy1); end
    endtask

    task automatic test_fill_readback();
        vid_ce = 1'b1; vid_addr = 10'h000; tick();
        checks++;
        if ({vid_rvalid0, vid_dout0} !== {1'b1, FILLV}) begin
            errors++; $display("FAIL fill_000_l1 got=%b/%h exp=1/%h", vid_rvalid0, vid_dout0, FILLV);
        end
        vid_addr = 10'h3FF; tick();
        checks++;
        if ({vid_rvalid0, vid_dout0, vid_rvalid1, vid_dout1} !== {1'b1, FILLV, 1'b1, FILLV}) begin
            errors++; $display("FAIL fill_3ff got=%b/%h %b/%h exp=1/%h 1/%h", vid_rvalid0, vid_dout0, vid_rvalid1, vid_dout1, FILLV, FILLV);
        end
        vid_ce = 1'b0; tick();
        checks++;
        if ({vid_rvalid0, vid_rvalid1, vid_dout1} !== {1'b0, 1'b1, FILLV}) begin
            errors++; $display("FAIL fill_drain got=%b %b/%h exp=0 1/%h", vid_rvalid0, vid_rvalid1, vid_dout1, FILLV);
        end
    endtask

    task automatic test_cpu_rw();
        cpu_ce = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h155; cpu_din = 4'h7; tick();
        checks++;
        if ({cpu_rvalid0, cpu_dout0} !== 5'b0_0000) begin
            errors++; $display("FAIL wr_no_rvalid got=%b/%h exp=0/0", cpu_rvalid0, cpu_dout0);
        end
        cpu_we = 1'b0; tick();
        checks++;
        if ({cpu_rvalid0, cpu_dout0, cpu_rvalid1} !== {1'b1, 4'h7, 1'b0}) begin
            errors++; $display("FAIL rd_l1 got=%b/%h %b exp=1/7 0", cpu_rvalid0, cpu_dout0, cpu_rvalid1);
        end
        cpu_ce = 1'b0; tick();
        checks++;
        if ({cpu_rvalid0, cpu_dout0, cpu_rvalid1, cpu_dout1} !== {1'b0, 4'h7, 1'b1, 4'h7}) begin
            errors++; $display("FAIL rd_l2 got=%b/%h %b/%h exp=0/7 1/7", cpu_rvalid0, cpu_dout0, cpu_rvalid1, cpu_dout1);
        end
    endtask

    task automatic test_collision();
        cpu_ce = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h020; cpu_din = 4'h9; tick();
        cpu_din = 4'h3; vid_ce = 1'b1; vid_addr = 10'h020; tick();
        checks++;
        if (vid_dout0 !== 4'h9) begin errors++; $display("FAIL coll_old got=%h exp=9", vid_dout0); end
        cpu_ce = 1'b0; tick();
        checks++;
        if ({vid_dout0, vid_dout1} !== {4'h3, 4'h9}) begin
            errors++; $display("FAIL coll_new got=%h %h exp=3 9", vid_dout0, vid_dout1);
        end
        vid_ce = 1'b0; tick();
    endtask

    task automatic test_busy_drop();
        int n;
        cpu_ce = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h010; cpu_din = 4'h1; tick();
        cpu_ce = 1'b0; clear_req = 1'b1; tick();
        clear_req = 1'b0;
        cpu_ce = 1'b1; cpu_we = 1'b1; cpu_din = 4'h5; tick();
        cpu_we = 1'b0; tick();
        checks++;
        if ({busy0, cpu_rvalid0, cpu_dout0, cpu_rvalid1} !== {1'b1, 1'b0, e_cd0, 1'b0}) begin
            errors++; $display("FAIL busy_drop got=%b %b/%h %b exp=1 0/%h 0", busy0, cpu_rvalid0, cpu_dout0, cpu_rvalid1, e_cd0);
        end
        cpu_ce = 1'b0;
        count_busy(n);
        cpu_ce = 1'b1; tick(); cpu_ce = 1'b0;
        checks++;
        if ({cpu_rvalid0, cpu_dout0} !== {1'b1, FILLV}) begin
            errors++; $display("FAIL busy_drop_fill got=%b/%h exp=1/%h", cpu_rvalid0, cpu_dout0, FILLV);
        end
        tick();
    endtask

    task automatic test_clear_restart();
        int n;
        clear_req = 1'b1; tick(); clear_req = 1'b0;
        repeat (500) tick();
        clear_req = 1'b1; tick(); clear_req = 1'b0;
        count_busy(n);
        checks++;
        if (n != DEPTH) begin errors++; $display("FAIL restart_len got=%0d exp=%0d", n, DEPTH); end
    endtask

    task automatic test_reset_mid_clear();
        int n;
        clear_req = 1'b1; tick(); clear_req = 1'b0;
        repeat (300) tick();
        vid_ce = 1'b1; vid_addr = 10'h3FF; tick();
        vid_ce = 1'b0;
        reset_n = 1'b0; #1;
        model_reset();
        checks++;
        if ({vid_rvalid0, vid_dout0, vid_rvalid1, vid_dout1, cpu_dout0, cpu_dout1} !== 18'b0) begin
            errors++; $display("FAIL midreset_out got=%b/%h %b/%h %h %h exp=0", vid_rvalid0, vid_dout0, vid_rvalid1, vid_dout1, cpu_dout0, cpu_dout1);
        end
        @(posedge clk); #1 reset_n = 1'b1;
        tick();
        checks++;
        if ({vid_rvalid1, busy1} !== 2'b01) begin
            errors++; $display("FAIL midreset_pending got=%b%b exp=01", vid_rvalid1, busy1);
        end
        count_busy(n);
        checks++;
        if (n != DEPTH - 1) begin errors++; $display("FAIL midreset_len got=%0d exp=%0d", n + 1, DEPTH); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 4000; c++) begin
            clear_req = ($urandom_range(0, 599) == 0);
            cpu_ce    = $urandom_range(0, 1);
            cpu_we    = $urandom_range(0, 1);
            cpu_addr  = 10'($urandom_range(0, 15));
            cpu_din   = 4'($urandom);
            vid_ce    = $urandom_range(0, 1);
            vid_addr  = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 15));
            tick();
            checks++;
            if ({busy0, cpu_rvalid0, cpu_dout0, vid_rvalid0, vid_dout0} !== {e_busy, e_cv0, e_cd0, e_vv0, e_vd0}) begin
                errors++; $display("FAIL rnd_dut0 cyc=%0d got=%b exp=%b", c,
                    {busy0, cpu_rvalid0, cpu_dout0, vid_rvalid0, vid_dout0}, {e_busy, e_cv0, e_cd0, e_vv0, e_vd0});
            end
            checks++;
            if ({busy1, cpu_rvalid1, cpu_dout1, vid_rvalid1, vid_dout1} !== {e_busy, e_cv1, e_cd1, e_vv1, e_vd1}) begin
                errors++; $display("FAIL rnd_dut1 cyc=%0d got=%b exp=%b", c,
                    {busy1, cpu_rvalid1, cpu_dout1, vid_rvalid1, vid_dout1}, {e_busy, e_cv1, e_cd1, e_vv1, e_vd1});
            end
        end
        idle_inputs();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mm[i] = 'x;
        idle_inputs();
        test_reset();
        test_clear_after_reset();
        test_fill_readback();
        test_cpu_rw();
        test_collision();
        test_busy_drop();
        test_clear_restart();
        test_reset_mid_clear();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
